// File: rtl/demux_stream_router.sv
// 1-to-NUM_OUT stream demultiplexer with valid/ready handshake.
// Each channel owns a one-entry output register and back-pressures on its own.
// Words go to channel in_sel, or to every channel when in_bcast is set.
// A unicast word aimed past the last channel is accepted, discarded and
// flagged on drop_pulse for one cycle.
module demux_stream_router #(
  parameter int WIDTH   = 16,
  parameter int NUM_OUT = 4,
  localparam int SEL_W  = $clog2(NUM_OUT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic                     drop_pulse,
  output logic                     busy
);

  // Per-channel state: the valid bit is the channel FSM.
  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  localparam logic [SEL_W:0] LP_NUM_OUT = NUM_OUT[SEL_W:0];

  logic [NUM_OUT-1:0]       r_state;
  logic [NUM_OUT*WIDTH-1:0] r_data;
  logic                     r_drop;

  logic [NUM_OUT-1:0]       w_free;
  logic [NUM_OUT-1:0]       w_sel_hit;
  logic [NUM_OUT-1:0]       w_load;
  logic [NUM_OUT-1:0]       w_state_d;
  logic [NUM_OUT*WIDTH-1:0] w_data_d;
  logic                     w_in_range;
  logic                     w_ready_raw;
  logic                     w_accept;
  logic                     w_drop_d;

  // Channel readiness and unicast target decode.
  always_comb begin
    w_free     = '0;
    w_sel_hit  = '0;
    w_in_range = ({1'b0, in_sel} < LP_NUM_OUT);
    for (int k = 0; k < NUM_OUT; k++) begin
      w_free[k]    = (r_state[k] == ST_EMPTY) | out_ready[k];
      w_sel_hit[k] = ({1'b0, in_sel} == k[SEL_W:0]);
    end
  end

  // Input handshake: broadcast needs every channel free, drops are always taken.
  always_comb begin
    if (in_bcast) begin
      w_ready_raw = &w_free;
    end else if (!w_in_range) begin
      w_ready_raw = 1'b1;
    end else begin
      w_ready_raw = |(w_free & w_sel_hit);
    end
    in_ready = rst_n & w_ready_raw;
    w_accept = in_valid & in_ready;
    w_drop_d = w_accept & ~in_bcast & ~w_in_range;
  end

  // Next state per channel: a reload wins over a drain in the same cycle.
  always_comb begin
    w_load    = '0;
    w_state_d = r_state;
    w_data_d  = r_data;
    for (int k = 0; k < NUM_OUT; k++) begin
      w_load[k] = w_accept & (in_bcast | w_sel_hit[k]);
      if (w_load[k]) begin
        w_state_d[k]                = ST_FULL;
        w_data_d[k*WIDTH +: WIDTH]  = in_data;
      end else if ((r_state[k] == ST_FULL) && out_ready[k]) begin
        w_state_d[k] = ST_EMPTY;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_data  <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_data  <= w_data_d;
      r_drop  <= w_drop_d;
    end
  end

  assign out_valid  = r_state;
  assign out_data   = r_data;
  assign drop_pulse = r_drop;
  assign busy       = |r_state;

endmodule
